filter_out_fifo: RTL and testbench

- Output buffer directly downstream of the single-MAC FIR filter.
- Captures each rounded 18-bit sample on the filter's DataNd strobe. The filter has no backpressure.
- Presents samples to the consumer over a valid/ready handshake.
- Reports occupancy and almost-full, and records samples lost to overflow.

---
 rtl/filter_out_fifo.sv | 114 +++++++++++
 tb/tb_filter_out_fifo.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/filter_out_fifo.sv
// Output FIFO behind the FIR filter: 16-sample first-word-fall-through buffer with an overflow
// record. Define OUT_FIFO_DROPCNT_EN to add the saturating DropCnt_o counter.
module filter_out_fifo #(
    parameter int unsigned dataWidth   = 18,
    parameter int unsigned addrWidth   = 4,
    parameter int unsigned afullThresh = 12
) (
    input  logic                 Clk_i,
    input  logic                 Rst_i,
    input  logic [dataWidth-1:0] Data_i,
    input  logic                 DataNd_i,
    output logic [dataWidth-1:0] Data_o,
    output logic                 DataValid_o,
    input  logic                 DataReady_i,
    output logic [addrWidth:0]   Level_o,
    output logic                 AlmostFull_o,
    output logic                 Overflow_o,
`ifdef OUT_FIFO_DROPCNT_EN
    output logic [7:0]           DropCnt_o,
`endif
    input  logic                 OvfClr_i
);

    localparam int unsigned depth = 1 << addrWidth;

    logic [dataWidth-1:0] mem [depth];
    logic [addrWidth-1:0] wrPtrQ, rdPtrQ;
    logic [dataWidth-1:0] dataQ;
    logic                 validQ;
    logic [addrWidth:0]   levelQ, levelNext;
    logic                 afullQ;
    logic                 ovfQ;

    logic pop, full, ramEmpty, wrAcc, drop, loadOut, bypass, ramWr, ramRd;

    // The RAM never holds more than depth-1 entries while the output register is valid and is
    // always empty when it is not, so equal pointers unambiguously mean an empty RAM.
    always_comb begin
        pop       = validQ && DataReady_i;
        full      = (levelQ == (addrWidth+1)'(depth));
        ramEmpty  = (wrPtrQ == rdPtrQ);
        wrAcc     = DataNd_i && (!full || pop);
        drop      = DataNd_i && full && !pop;
        loadOut   = !validQ || pop;
        bypass    = loadOut && ramEmpty && wrAcc;
        ramWr     = wrAcc && !bypass;
        ramRd     = loadOut && !ramEmpty;
        levelNext = levelQ + (addrWidth+1)'(wrAcc) - (addrWidth+1)'(pop);
    end

    always_ff @(posedge Clk_i) begin
        if (Rst_i && ramWr) begin
            mem[wrPtrQ] <= Data_i;
        end
    end

    always_ff @(posedge Clk_i) begin
        if (!Rst_i) begin
            wrPtrQ <= '0;
            rdPtrQ <= '0;
            dataQ  <= '0;
            validQ <= 1'b0;
            levelQ <= '0;
            afullQ <= 1'b0;
            ovfQ   <= 1'b0;
        end else begin
            if (ramWr) begin
                wrPtrQ <= wrPtrQ + addrWidth'(1);
            end
            if (ramRd) begin
                rdPtrQ <= rdPtrQ + addrWidth'(1);
            end
            if (loadOut) begin
                validQ <= !ramEmpty || wrAcc;
                if (ramRd) begin
                    dataQ <= mem[rdPtrQ];
                end else if (bypass) begin
                    dataQ <= Data_i;
                end
            end
            levelQ <= levelNext;
            afullQ <= (levelNext >= (addrWidth+1)'(afullThresh));
            // A drop takes priority over a clear request in the same cycle.
            if (drop) begin
                ovfQ <= 1'b1;
            end else if (OvfClr_i) begin
                ovfQ <= 1'b0;
            end
        end
    end

`ifdef OUT_FIFO_DROPCNT_EN
    logic [7:0] dropCntQ;

    always_ff @(posedge Clk_i) begin
        if (!Rst_i) begin
            dropCntQ <= '0;
        end else if (OvfClr_i) begin
            dropCntQ <= drop ? 8'd1 : 8'd0;
        end else if (drop && (dropCntQ != 8'hFF)) begin
            dropCntQ <= dropCntQ + 8'd1;
        end
    end

    assign DropCnt_o = dropCntQ;
`endif

    assign Data_o       = dataQ;
    assign DataValid_o  = validQ;
    assign Level_o      = levelQ;
    assign AlmostFull_o = afullQ;
    assign Overflow_o   = ovfQ;

endmodule

// File: tb/tb_filter_out_fifo.sv
// Scoreboard bench for filter_out_fifo: stimulus pushes expected samples, a negedge monitor
// checks every pop in order; levels and flags are checked directly in the stimulus thread.
module tb_filter_out_fifo;

    logic        Clk_i = 1'b0;
    logic        Rst_i;
    logic [17:0] Data_i;
    logic        DataNd_i;
    logic [17:0] Data_o;
    logic        DataValid_o;
    logic        DataReady_i;
    logic [4:0]  Level_o;
    logic        AlmostFull_o;
    logic        Overflow_o;
    logic        OvfClr_i;
`ifdef OUT_FIFO_DROPCNT_EN
    logic [7:0]  DropCnt_o;
`endif

    int total = 0;
    int bad   = 0;
    logic [17:0] expQ [$];

    filter_out_fifo dut (
        .Clk_i       (Clk_i),
        .Rst_i       (Rst_i),
        .Data_i      (Data_i),
        .DataNd_i    (DataNd_i),
        .Data_o      (Data_o),
        .DataValid_o (DataValid_o),
        .DataReady_i (DataReady_i),
        .Level_o     (Level_o),
        .AlmostFull_o(AlmostFull_o),
        .Overflow_o  (Overflow_o),
`ifdef OUT_FIFO_DROPCNT_EN
        .DropCnt_o   (DropCnt_o),
`endif
        .OvfClr_i    (OvfClr_i)
    );

    always #5 Clk_i = ~Clk_i;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk_i);
        #1;
    endtask

    // Monitor: a pop happens at the next rising edge whenever valid and ready are both high.
    always @(negedge Clk_i) begin
        if (Rst_i === 1'b1 && DataValid_o === 1'b1 && DataReady_i === 1'b1) begin
            total++;
            if (expQ.size() == 0) begin
                bad++;
                $display("FAIL pop: got 0x%0h expected no sample", Data_o);
            end else begin
                if (Data_o !== expQ[0]) begin
                    bad++;
                    $display("FAIL pop: got 0x%0h expected 0x%0h", Data_o, expQ[0]);
                end
                void'(expQ.pop_front());
            end
        end
    end

    task automatic write(input logic [17:0] v, input bit expectAccept);
        DataNd_i = 1'b1;
        Data_i   = v;
        if (expectAccept) expQ.push_back(v);
        tick();
        DataNd_i = 1'b0;
    endtask

    initial begin
        Rst_i       = 1'b0;
        Data_i      = '0;
        DataNd_i    = 1'b0;
        DataReady_i = 1'b0;
        OvfClr_i    = 1'b0;
        repeat (3) tick();
        Rst_i = 1'b1;
        tick();
        chk("rst_level", Level_o, 0);
        chk("rst_valid", DataValid_o, 0);
        chk("rst_data", Data_o, 0);
        chk("rst_afull", AlmostFull_o, 0);
        chk("rst_ovf", Overflow_o, 0);

        // Single sample, one-cycle latency.
        DataReady_i = 1'b1;
        write(18'h00123, 1'b1);
        chk("t1_valid", DataValid_o, 1);
        chk("t1_data", Data_o, 'h123);
        chk("t1_level", Level_o, 1);
        tick();
        chk("t1_level_after", Level_o, 0);
        chk("t1_valid_after", DataValid_o, 0);

        // Fill to full with no consumer.
        DataReady_i = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            write(18'(i), 1'b1);
            chk("t2_level", Level_o, i);
            chk("t2_afull", AlmostFull_o, (i >= 12) ? 1 : 0);
            chk("t2_head", Data_o, 1);
        end
        chk("t2_ovf", Overflow_o, 0);

        // Three drops into a full block.
        for (int j = 0; j < 3; j++) begin
            write(18'(100 + j), 1'b0);
            chk("t3_level", Level_o, 16);
        end
        chk("t3_ovf", Overflow_o, 1);
`ifdef OUT_FIFO_DROPCNT_EN
        chk("t3_dropcnt", DropCnt_o, 3);
`endif

        // Write with simultaneous pop at full: accepted, level unchanged.
        DataReady_i = 1'b1;
        write(18'd17, 1'b1);
        chk("t4_level", Level_o, 16);
        chk("t4_ovf", Overflow_o, 1);
`ifdef OUT_FIFO_DROPCNT_EN
        chk("t4_dropcnt", DropCnt_o, 3);
`endif
        repeat (16) tick();
        chk("t4_drain_level", Level_o, 0);
        chk("t4_drain_valid", DataValid_o, 0);
        chk("t4_drain_queue", expQ.size(), 0);

        // Refill, then drop together with a clear request.
        DataReady_i = 1'b0;
        for (int i = 1; i <= 16; i++) write(18'(200 + i), 1'b1);
        chk("t5_level", Level_o, 16);
        OvfClr_i = 1'b1;
        write(18'd999, 1'b0);
        chk("t5_ovf_set_wins", Overflow_o, 1);
`ifdef OUT_FIFO_DROPCNT_EN
        chk("t5_dropcnt_one", DropCnt_o, 1);
`endif
        tick();
        OvfClr_i = 1'b0;
        chk("t5_ovf_clr", Overflow_o, 0);
`ifdef OUT_FIFO_DROPCNT_EN
        chk("t5_dropcnt_clr", DropCnt_o, 0);
`endif

        // Drain to 9 then reset mid-operation.
        DataReady_i = 1'b1;
        repeat (7) tick();
        DataReady_i = 1'b0;
        chk("t6_level", Level_o, 9);
        chk("t6_valid", DataValid_o, 1);
        chk("t6_head", Data_o, 208);
        Rst_i = 1'b0;
        tick();
        expQ.delete();
        Rst_i = 1'b1;
        chk("t6_rst_level", Level_o, 0);
        chk("t6_rst_valid", DataValid_o, 0);
        chk("t6_rst_data", Data_o, 0);
        chk("t6_rst_afull", AlmostFull_o, 0);
        chk("t6_rst_ovf", Overflow_o, 0);
        DataReady_i = 1'b1;
        repeat (2) tick();
        chk("t6_idle_valid", DataValid_o, 0);
        write(18'h3FFFF, 1'b1);
        chk("t6_first_data", Data_o, 'h3FFFF);
        chk("t6_first_valid", DataValid_o, 1);
        tick();
        chk("t6_end_level", Level_o, 0);
        chk("t6_end_queue", expQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
